// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - request/read/status bundle between the execute stage and the muldiv unit
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             rd_req;
  logic             rd_sel;
  logic [WIDTH-1:0] rd_data;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             stall;
  logic             done;
  logic             dz;

  // Pipeline side: issues operations and HI/LO reads.
  modport master (
    output start, op, a, b, rd_req, rd_sel,
    input  rd_data, hi, lo, busy, stall, done, dz
  );

  // Unit side: owns HI/LO and the status outputs.
  modport slave (
    input  start, op, a, b, rd_req, rd_sel,
    output rd_data, hi, lo, busy, stall, done, dz
  );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative signed MULT/DIV unit holding the HI/LO registers
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         reset,
  muldiv_unit_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               op_q, op_d;
  logic               sa_q, sa_d;
  logic               sb_q, sb_d;
  logic [WIDTH-1:0]   bmag_q, bmag_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               dz_q, dz_d;

  logic [WIDTH-1:0]   amag_in;
  logic [WIDTH-1:0]   bmag_in;
  logic [WIDTH:0]     msum;
  logic [WIDTH:0]     r_sh;
  logic [WIDTH:0]     r_diff;
  logic               r_ge;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;

  // Datapath: operand magnitudes, one shift-add / shift-subtract step, and sign fix-up values.
  // The accumulator is shared: MULT keeps {partial product, remaining multiplier},
  // DIV keeps {partial remainder, dividend bits shifting into quotient bits}.
  always_comb begin
    amag_in = bus.a[WIDTH-1] ? -bus.a : bus.a;
    bmag_in = bus.b[WIDTH-1] ? -bus.b : bus.b;

    msum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{acc_q[0]}} & bmag_q};

    r_sh    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    r_ge    = (r_sh >= {1'b0, bmag_q});
    r_diff  = r_sh - {1'b0, bmag_q};

    prod    = (sa_q ^ sb_q) ? -acc_q : acc_q;
    quo     = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    // With a zero divisor every step subtracts nothing, so the remainder ends up as |a|
    // and the sign correction below restores the original dividend for HI.
    rem     = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  // Next-state and register updates for the IDLE -> CALC -> FIXUP sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    bmag_d  = bmag_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dz_d    = dz_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          op_d    = bus.op;
          sa_d    = bus.a[WIDTH-1];
          sb_d    = bus.b[WIDTH-1];
          bmag_d  = bmag_in;
          acc_d   = {{WIDTH{1'b0}}, amag_in};
          cnt_d   = '0;
          dz_d    = 1'b0;
          state_d = CALC;
        end
      end

      CALC: begin
        if (op_q) begin
          acc_d = {(r_ge ? r_diff[WIDTH-1:0] : r_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], r_ge};
        end else begin
          acc_d = {msum, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = FIXUP;
        end
      end

      FIXUP: begin
        if (op_q) begin
          hi_d = rem;
          if (bmag_q == '0) begin
            lo_d = '1;
            dz_d = 1'b1;
          end else begin
            lo_d = quo;
          end
        end else begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset abandons any operation in flight without touching HI/LO afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      bmag_q  <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      bmag_q  <= bmag_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;
  assign bus.busy    = (state_q != IDLE);
  assign bus.stall   = bus.rd_req & (state_q != IDLE);
  assign bus.rd_data = bus.rd_sel ? hi_q : lo_q;
  assign bus.done    = done_q;
  assign bus.dz      = dz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit
module tb_muldiv_unit;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  muldiv_unit_if #(.WIDTH(32)) bus ();

  muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issues one operation and follows it to the done pulse (bounded at 40 cycles).
  // k counts negedges after the start edge; done is expected at k = 34.
  task automatic run_op(input logic o, input logic [31:0] av, input logic [31:0] bv,
                        input bit rd, input bit restart,
                        output int lat, output int busy_n, output int stall_bad,
                        output logic dz_k1);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = av;
    bus.b     = bv;
    lat       = 0;
    busy_n    = 0;
    stall_bad = 0;
    dz_k1     = 1'bx;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.start = 1'b0;
        bus.op    = ~o;
        bus.a     = $urandom;
        bus.b     = $urandom;
        if (rd) begin
          bus.rd_req = 1'b1;
          bus.rd_sel = 1'b1;
        end
      end
      if (restart && k == 10) bus.start = 1'b1;
      if (restart && k == 11) bus.start = 1'b0;
      #1;
      if (k == 1) dz_k1 = bus.dz;
      if (bus.done) begin
        lat = k;
        break;
      end
      if (bus.busy) busy_n++;
      if (rd && bus.busy && !bus.stall) stall_bad++;
    end
  endtask

  int   lat, bn, sbad, quiet;
  logic dzk;

  initial begin
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.op     = 1'b0;
    bus.a      = '0;
    bus.b      = '0;
    bus.rd_req = 1'b0;
    bus.rd_sel = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_hi",   bus.hi, 32'd0);
    chk("rst_lo",   bus.lo, 32'd0);
    chk("rst_done", {31'b0, bus.done}, 32'd0);
    chk("rst_dz",   {31'b0, bus.dz}, 32'd0);
    reset = 1'b0;

    // 7 * -3 = -21
    run_op(1'b0, 32'd7, 32'hFFFFFFFD, 1'b0, 1'b0, lat, bn, sbad, dzk);
    chk("m1_lat",  lat, 32'd34);
    chk("m1_busy", bn, 32'd33);
    chk("m1_hi",   bus.hi, 32'hFFFFFFFF);
    chk("m1_lo",   bus.lo, 32'hFFFFFFEB);
    chk("m1_dz",   {31'b0, bus.dz}, 32'd0);

    // -7 / 2 = -3 rem -1
    run_op(1'b1, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0, lat, bn, sbad, dzk);
    chk("d1_lat", lat, 32'd34);
    chk("d1_lo",  bus.lo, 32'hFFFFFFFD);
    chk("d1_hi",  bus.hi, 32'hFFFFFFFF);

    // 100 / 7 = 14 rem 2
    run_op(1'b1, 32'd100, 32'd7, 1'b0, 1'b0, lat, bn, sbad, dzk);
    chk("d2_lo", bus.lo, 32'd14);
    chk("d2_hi", bus.hi, 32'd2);

    // 5 / 0
    run_op(1'b1, 32'd5, 32'd0, 1'b0, 1'b0, lat, bn, sbad, dzk);
    chk("dz_hi", bus.hi, 32'd5);
    chk("dz_lo", bus.lo, 32'hFFFFFFFF);
    chk("dz_dz", {31'b0, bus.dz}, 32'd1);

    // MULT most-negative squared; its start edge clears dz
    run_op(1'b0, 32'h80000000, 32'h80000000, 1'b0, 1'b0, lat, bn, sbad, dzk);
    chk("dz_clear", {31'b0, dzk}, 32'd0);
    chk("mn2_hi",   bus.hi, 32'h40000000);
    chk("mn2_lo",   bus.lo, 32'd0);

    // most-negative / -1 wraps
    run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, lat, bn, sbad, dzk);
    chk("ovf_lo", bus.lo, 32'h80000000);
    chk("ovf_hi", bus.hi, 32'd0);
    chk("ovf_dz", {31'b0, bus.dz}, 32'd0);

    // -5 * 6 = -30 with MFHI held pending and a stray start mid-CALC
    run_op(1'b0, 32'hFFFFFFFB, 32'd6, 1'b1, 1'b1, lat, bn, sbad, dzk);
    chk("st_lat",     lat, 32'd34);
    chk("st_busy",    bn, 32'd33);
    chk("st_stall",   sbad, 32'd0);
    chk("st_stall_d", {31'b0, bus.stall}, 32'd0);
    chk("st_rdata",   bus.rd_data, 32'hFFFFFFFF);
    chk("st_lo",      bus.lo, 32'hFFFFFFE2);
    bus.rd_req = 1'b0;
    bus.rd_sel = 1'b0;

    // DIV abandoned by reset ten cycles in
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 1'b1;
    bus.a     = 32'd100;
    bus.b     = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("ar_busy", {31'b0, bus.busy}, 32'd0);
    chk("ar_hi",   bus.hi, 32'd0);
    chk("ar_lo",   bus.lo, 32'd0);
    chk("ar_done", {31'b0, bus.done}, 32'd0);
    reset = 1'b0;
    quiet = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done || bus.busy) quiet++;
    end
    chk("ar_quiet", quiet, 32'd0);

    // 3 * 4 after reset
    run_op(1'b0, 32'd3, 32'd4, 1'b0, 1'b0, lat, bn, sbad, dzk);
    chk("m3_lat", lat, 32'd34);
    chk("m3_lo",  bus.lo, 32'd12);
    chk("m3_hi",  bus.hi, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multi-cycle multiply/divide unit holding the architectural HI/LO registers for the MIPS core.
- Executes signed MULT and DIV over WIDTH cycles and serves MFHI/MFLO reads.
- Asserts stall toward the pipeline when a HI/LO read arrives while an operation is in flight.
- Sits beside the ALU in the execute stage. The control path issues start/op from the decoded R-type funct field.

Parameters:
- WIDTH, 32, operand/HI/LO width in bits; must be >= 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request a new operation; sampled only in IDLE
- op  input  1  0 = MULT (signed), 1 = DIV (signed)
- a  input  WIDTH  rs operand: multiplicand or dividend
- b  input  WIDTH  rt operand: multiplier or divisor
- rd_req  input  1  MFHI/MFLO read request
- rd_sel  input  1  0 = LO, 1 = HI
- rd_data  output  WIDTH  combinational: rd_sel ? hi : lo
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register
- busy  output  1  high while state != IDLE
- stall  output  1  combinational rd_req & busy
- done  output  1  registered one-cycle pulse when HI/LO update
- dz  output  1  divide-by-zero flag for the last completed DIV

Behaviour:
- Reset (synchronous, overrides everything):
  - state = IDLE; hi = lo = 0; busy = done = dz = 0; iteration counter = 0.
  - Reset mid-operation abandons the operation. No HI/LO write or done pulse follows.
- States: IDLE -> CALC -> FIXUP -> IDLE.
- IDLE:
  - On an edge with start = 1, latch |a|, |b|, the operand signs and op. Clear the counter and clear dz, then go to CALC.
  - start = 0 stays in IDLE.
  - done is cleared on every edge except the FIXUP exit edge.
- CALC:
  - One iteration per edge on unsigned magnitudes.
  - MULT: shift-add into a 2*WIDTH accumulator.
  - DIV: restoring shift-subtract producing a WIDTH quotient and a WIDTH remainder.
  - After WIDTH iterations (counter = WIDTH-1 on that edge), go to FIXUP.
- FIXUP:
  - One edge applies sign correction and writes hi/lo, sets done = 1, and returns to IDLE.
  - MULT: product = sign(a) xor sign(b) ? -|P| : |P|; hi = product[2W-1:W], lo = product[W-1:0].
  - DIV: quotient truncates toward zero, negated if the signs differ; remainder takes the sign of the dividend. lo = quotient, hi = remainder.
  - DIV with b = 0: hi = a (original), lo = all ones, dz = 1.
  - DIV with a = most-negative and b = -1: lo = most-negative (wraps), hi = 0, dz = 0.
- Latency:
  - Start accepted at edge E0; hi/lo/done update at edge E0+WIDTH+1.
  - busy is high for the WIDTH+1 cycles between those edges.
- start while busy is ignored; operands are not re-latched.
- start in the done cycle is accepted: state is IDLE, and busy rises after that edge.
- hi/lo hold their old values until FIXUP, so rd_data during busy shows stale data. This is why stall is asserted.
- stall falls in the done cycle, and rd_data then returns the new value combinationally.
- dz holds until the next accepted start.
- Operand inputs may change freely after the start edge.

Test Plan:
- Reset, then MULT a=7, b=0xFFFFFFFD (-3) -> busy for 33 cycles; done after edge E0+33; hi=0xFFFFFFFF, lo=0xFFFFFFEB, dz=0.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Repeat with a=100, b=7 -> lo=14, hi=2.
- DIV a=5, b=0 -> hi=5, lo=0xFFFFFFFF, dz=1. A following MULT start clears dz on its start edge.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0. MULT a=0x80000000, b=0x80000000 -> hi=0x40000000, lo=0.
- rd_req=1, rd_sel=1 held from the cycle after start -> stall=1 every busy cycle, 0 in the done cycle with rd_data=new hi. A second start pulsed mid-CALC is ignored: result and latency unchanged.
- After a completed MULT (hi/lo nonzero), start a DIV and assert reset at cycle 10 -> next cycle: busy=0, hi=lo=0, no done pulse. A fresh MULT 3*4 then gives lo=12, hi=0.
